// File: rtl/fprint_scratchpad_pkg.sv
// Shared constants and types for the fingerprint scratchpad arbiter.
// Holds port indices, default bus widths and the priority-mode selectors.
package fprint_scratchpad_pkg;

    // Requester indices
    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    // Default bus geometry (4096 x 32 scratchpad)
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

    // Arbitration modes
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // One-bit port selector used for last-grant and read-return tracking
    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_DMA = 1'b1
    } port_sel_e;

    // A request with both read and write set is a write and gets no response
    function automatic logic is_read_only(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/fprint_rr_arbiter2.sv
// Two-requester grant logic with the last-grant history register.
// Ports: clk, reset_n, block (suppress grants), req[1:0] in; grant[1:0] out.
module fprint_rr_arbiter2
    import fprint_scratchpad_pkg::*;
#(
    parameter int FIXED_PRIORITY = PRIO_RR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       block,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    port_sel_e last_grant;
    logic      cpu_wins_tie;

    // On a tie the CPU wins in fixed mode, or when the DMA went last
    assign cpu_wins_tie = (FIXED_PRIORITY == PRIO_FIXED) ||
                          (last_grant == SEL_DMA);

    always_comb begin
        grant = 2'b00;
        if (!block) begin
            if (req == 2'b11) begin
                grant = cpu_wins_tie ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Reset to DMA so the CPU takes the very first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= SEL_DMA;
        end else if (|grant) begin
            last_grant <= grant[1] ? SEL_DMA : SEL_CPU;
        end
    end

endmodule

// File: rtl/fprint_scratchpad_arbiter.sv
// Shares one single-port scratchpad RAM between the CPU and DMA masters.
// Ports: p0_*/p1_* Avalon-MM slaves, ram_* RAM drive, reset_req gates grants.
module fprint_scratchpad_arbiter
    import fprint_scratchpad_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BE_WIDTH       = DEF_BE_WIDTH,
    parameter int FIXED_PRIORITY = PRIO_RR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reset_req,

    input  logic                  p0_chipselect,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic [BE_WIDTH-1:0]   p0_byteenable,
    input  logic [DATA_WIDTH-1:0] p0_writedata,
    output logic                  p0_waitrequest,
    output logic                  p0_readdatavalid,
    output logic [DATA_WIDTH-1:0] p0_readdata,

    input  logic                  p1_chipselect,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic [BE_WIDTH-1:0]   p1_byteenable,
    input  logic [DATA_WIDTH-1:0] p1_writedata,
    output logic                  p1_waitrequest,
    output logic                  p1_readdatavalid,
    output logic [DATA_WIDTH-1:0] p1_readdata,

    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [BE_WIDTH-1:0]   ram_byteenable,
    output logic [DATA_WIDTH-1:0] ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_WIDTH-1:0] ram_readdata
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       sel_dma;
    logic       rd_grant;
    logic       rd_pend_valid;
    port_sel_e  rd_pend_port;

    assign req[PORT_CPU] = p0_chipselect & (p0_read | p0_write);
    assign req[PORT_DMA] = p1_chipselect & (p1_read | p1_write);

    fprint_rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .block   (reset_req),
        .req     (req),
        .grant   (grant)
    );

    assign p0_waitrequest = req[PORT_CPU] & ~grant[PORT_CPU];
    assign p1_waitrequest = req[PORT_DMA] & ~grant[PORT_DMA];

    // With no grant the mux rests on the CPU port
    assign sel_dma = grant[PORT_DMA];

    assign ram_chipselect = |grant;
    assign ram_address    = sel_dma ? p1_address    : p0_address;
    assign ram_byteenable = sel_dma ? p1_byteenable : p0_byteenable;
    assign ram_writedata  = sel_dma ? p1_writedata  : p0_writedata;
    assign ram_write      = (grant[PORT_CPU] & p0_write) |
                            (grant[PORT_DMA] & p1_write);

    // Freezing the RAM clock also holds q, so an in-flight read survives
    assign ram_clken = ~reset_req;

    assign rd_grant =
        (grant[PORT_CPU] & is_read_only(p0_read, p0_write)) |
        (grant[PORT_DMA] & is_read_only(p1_read, p1_write));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_valid <= 1'b0;
            rd_pend_port  <= SEL_CPU;
        end else begin
            rd_pend_valid <= rd_grant;
            if (rd_grant) begin
                rd_pend_port <= sel_dma ? SEL_DMA : SEL_CPU;
            end
        end
    end

    assign p0_readdatavalid = rd_pend_valid & (rd_pend_port == SEL_CPU);
    assign p1_readdatavalid = rd_pend_valid & (rd_pend_port == SEL_DMA);

    // Data is shared; readdatavalid alone says whose it is
    assign p0_readdata = ram_readdata;
    assign p1_readdata = ram_readdata;

endmodule

// File: doc/fprint_scratchpad_arbiter.md
Name: fprint_scratchpad_arbiter

Overview:
Two-port Avalon-MM arbiter that shares one single-port 4096x32 scratchpad RAM (1-cycle read latency, byte enables, clock enable) between the Nios core data master (port 0) and the fingerprint/DMA master (port 1). It grants one access per cycle, steers address, data and byte enables to the RAM, and routes read data back with a per-port readdatavalid. It sits between the interconnect and the scratchpad instance inside each processor subsystem.

Parameters:
ADDR_WIDTH, 12, word address width (4096 words)
DATA_WIDTH, 32, data width
BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
FIXED_PRIORITY, 0, 0 = round-robin on contention; 1 = port 0 always wins

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
reset_req  in  1  reset request; blocks new grants and gates RAM clock enable
p0_chipselect  in  1  port 0 select
p0_read  in  1  port 0 read request
p0_write  in  1  port 0 write request
p0_address  in  ADDR_WIDTH  port 0 word address
p0_byteenable  in  BE_WIDTH  port 0 byte enables
p0_writedata  in  DATA_WIDTH  port 0 write data
p0_waitrequest  out  1  port 0 stall
p0_readdatavalid  out  1  port 0 read data valid
p0_readdata  out  DATA_WIDTH  port 0 read data
p1_*  (same nine signals as p0_*, same widths and directions)
ram_chipselect  out  1  RAM select
ram_write  out  1  RAM write
ram_address  out  ADDR_WIDTH  RAM address
ram_byteenable  out  BE_WIDTH  RAM byte enables
ram_writedata  out  DATA_WIDTH  RAM write data
ram_clken  out  1  RAM clock enable
ram_readdata  in  DATA_WIDTH  RAM q, valid 1 cycle after read address

Behaviour:
- reset_n = 0 is async. While asserted: last_grant = 1 (port 0 wins the first tie), rd_pend_valid = 0, rd_pend_port = 0. Both readdatavalid = 0. Waitrequest follows the combinational rule below.
- reqN = pN_chipselect & (pN_read | pN_write). Read and write asserted together: treated as a write, no read response.
- Grant (combinational, same cycle):
  - reset_req = 1: no grant.
  - Only one port requesting: that port is granted.
  - Both requesting: FIXED_PRIORITY = 1 grants port 0. FIXED_PRIORITY = 0 grants the port != last_grant.
- last_grant is updated on every cycle that has a grant.
- pN_waitrequest = reqN & ~grantN. This is 1 for a port that loses or is blocked by reset_req, and 0 when the port is idle.
- RAM drive:
  - ram_chipselect = grant0 | grant1.
  - address, byteenable and writedata are muxed from the granted port; with no grant they come from port 0.
  - ram_write = granted port's write.
  - ram_clken = ~reset_req.
- Read pipeline: a granted read sets rd_pend_valid = 1 and rd_pend_port = granted index at the clock edge. Otherwise rd_pend_valid = 0.
- Read response: pN_readdatavalid = rd_pend_valid & (rd_pend_port == N), exactly 1 cycle after the grant. pN_readdata = ram_readdata on both ports, qualified only by readdatavalid.
- Throughput: one access per cycle, fully pipelined. Back-to-back reads from alternating ports return in grant order.
- Writes complete in the grant cycle with no response.
- reset_req asserted while a read is pending: the pending response is still delivered. RAM q holds because it was captured at the grant edge.
- reset_n asserted mid-read: the pending response is dropped, with no readdatavalid after reset release.
- Sustained contention under round-robin: strict alternation, max wait 1 cycle per access.

Decomposition:
- Shared package fprint_scratchpad_pkg holds:
  - port index constants (PORT_CPU = 0, PORT_DMA = 1)
  - default ADDR/DATA/BE widths
  - priority-mode constants (PRIO_RR, PRIO_FIXED)
- Sub-module fprint_rr_arbiter2: 2-requester grant logic plus the last_grant register, with FIXED_PRIORITY passed through.
- Top level holds the RAM mux and the read-pending pipeline.

Test Plan:
- Reset: reset_n = 0 with both ports idle, then release -> all readdatavalid = 0, ram_chipselect = 0, ram_clken = 1.
- Single-port write then read: p0 writes 0xDEADBEEF at 0x012 with BE = 0xF, then reads 0x012 -> both granted with waitrequest = 0, p0_readdatavalid 1 cycle after the read grant, data 0xDEADBEEF, p1_readdatavalid = 0.
- Byte enables: p1 writes 0x11223344 to 0xFFF, then writes 0xAABBCCDD with BE = 0x2, then reads 0xFFF -> 0x1122CC44.
- Contention, round-robin: both ports read every cycle for 6 cycles at addresses 0x100 (p0) and 0x200 (p1), preloaded with distinct values -> grants alternate p0, p1, p0, ... Each port's waitrequest is high on alternate cycles, and data returns to the correct port 1 cycle after each grant.
- FIXED_PRIORITY = 1 with both ports requesting for 4 cycles -> p0 granted every cycle and p1_waitrequest held high. After p0 drops its request, p1 is granted the same cycle.
- reset_req and reset_n mid-read:
  - reset_req rises the cycle after a p0 read grant -> p0 still receives readdatavalid with correct data, both requesters then see waitrequest = 1, and ram_clken = 0.
  - Separately, reset_n asserted the cycle after a read grant -> no readdatavalid.
